// File: rtl/apb_master_requester_if.sv
// Command, response and APB bus bundle for the requester; master = requester side.
interface apb_master_requester_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_error_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           prdata_i, pready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           prdata_i, pready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_master_requester.sv
// APB requester: one command -> SETUP+ACCESS transfer with pready timeout -> held response.
// Zero-wait latency: accept edge N, response visible after edge N+2; cmd_ready only in IDLE.
module apb_master_requester #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  apb_master_requester_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;
  logic [CW-1:0]         cnt_q;
  logic                  timeout_hit;

  // Counter holds the number of wait cycles already spent in ACCESS.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            paddr_q   <= bus.cmd_addr_i;
            pwrite_q  <= bus.cmd_write_i;
            pwdata_q  <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata_i;
            rsp_error_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;
endmodule

// File: tb/tb_apb_master_requester.sv
// Bench for apb_master_requester: directed scenarios plus random transfers vs a latency/response model.
module tb_apb_master_requester;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  apb_master_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk_i   (clk),
    .preset_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Model: w wait states -> response after 3+w cycles, capped by the timeout at TO ACCESS cycles.
  function automatic int model_wait(input int w);
    return (w >= TO) ? TO - 1 : w;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rd_val, input int waits, input int hold,
                          input bit poke);
    int k, acc, n_sel, n_en;
    bit done, exp_err;
    logic [DW-1:0] exp_wd, exp_rd;
    exp_err = (waits >= TO);
    exp_wd  = wr ? wdata : '0;
    exp_rd  = (wr || exp_err) ? '0 : rd_val;

    expect_eq("cmd_ready_idle", 32'(bus.cmd_ready_o), 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'($urandom);
    bus.cmd_addr_i  = AW'($urandom);
    bus.cmd_wdata_i = DW'($urandom);

    k = 1; acc = 0; n_sel = 0; n_en = 0; done = 0;
    while (!done && k <= 40) begin
      if (bus.rsp_valid_o) begin
        done = 1;
      end else begin
        if (bus.psel_o) begin
          n_sel++;
          expect_eq("paddr", 32'(bus.paddr_o), 32'(addr));
          expect_eq("pwrite", 32'(bus.pwrite_o), 32'(wr));
          expect_eq("pwdata", 32'(bus.pwdata_o), 32'(exp_wd));
        end
        if (bus.penable_o) begin
          n_en++;
          expect_eq("penable_needs_psel", 32'(bus.psel_o), 1);
        end
        if (bus.psel_o && bus.penable_o) begin
          bus.pready_i = (acc >= waits);
          bus.prdata_i = rd_val;
          acc++;
        end else begin
          bus.pready_i = 1'($urandom);
          bus.prdata_i = DW'($urandom);
        end
        @(posedge clk); @(negedge clk);
        k++;
      end
    end
    bus.pready_i = 1'b0;

    expect_eq("rsp_valid_seen", 32'(bus.rsp_valid_o), 1);
    expect_eq("rsp_latency", 32'(k), 32'(3 + model_wait(waits)));
    expect_eq("rsp_error", 32'(bus.rsp_error_o), 32'(exp_err));
    expect_eq("rsp_rdata", 32'(bus.rsp_rdata_o), 32'(exp_rd));
    expect_eq("psel_after_done", 32'(bus.psel_o), 0);
    expect_eq("penable_after_done", 32'(bus.penable_o), 0);
    expect_eq("cmd_ready_resp", 32'(bus.cmd_ready_o), 0);
    expect_eq("penable_cycles", 32'(n_en), 32'(model_wait(waits) + 1));
    expect_eq("psel_cycles", 32'(n_sel), 32'(model_wait(waits) + 2));

    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready_i = 1'b0;
      if (poke) bus.cmd_valid_i = 1'b1;
      @(posedge clk); @(negedge clk);
      expect_eq("hold_rsp_valid", 32'(bus.rsp_valid_o), 1);
      expect_eq("hold_cmd_ready", 32'(bus.cmd_ready_o), 0);
      expect_eq("hold_psel", 32'(bus.psel_o), 0);
      expect_eq("hold_rdata", 32'(bus.rsp_rdata_o), 32'(exp_rd));
      expect_eq("hold_error", 32'(bus.rsp_error_o), 32'(exp_err));
    end
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    expect_eq("rsp_valid_cleared", 32'(bus.rsp_valid_o), 0);
    expect_eq("cmd_ready_back", 32'(bus.cmd_ready_o), 1);
    expect_eq("psel_idle", 32'(bus.psel_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    #1;
    expect_eq("rst_psel", 32'(bus.psel_o), 0);
    expect_eq("rst_penable", 32'(bus.penable_o), 0);
    expect_eq("rst_pwrite", 32'(bus.pwrite_o), 0);
    expect_eq("rst_paddr", 32'(bus.paddr_o), 0);
    expect_eq("rst_pwdata", 32'(bus.pwdata_o), 0);
    expect_eq("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    expect_eq("rst_rsp_rdata", 32'(bus.rsp_rdata_o), 0);
    expect_eq("rst_rsp_error", 32'(bus.rsp_error_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("post_rst_cmd_ready", 32'(bus.cmd_ready_o), 1);

    run_xfer(1'b1, 8'h05, 8'h3C, 8'h00, 0, 0, 1'b0);    // plain write, zero wait
    run_xfer(1'b0, 8'h02, 8'h77, 8'hA5, 0, 0, 1'b0);    // read returns slave data
    run_xfer(1'b1, 8'h04, 8'h9E, 8'h00, 3, 0, 1'b0);    // three wait states
    run_xfer(1'b0, 8'h10, 8'h00, 8'hC3, 1000, 0, 1'b0); // pready stuck low -> timeout
    run_xfer(1'b0, 8'h11, 8'h00, 8'h5A, 15, 0, 1'b0);   // ready on final cycle wins
    run_xfer(1'b1, 8'h20, 8'h81, 8'h00, 1, 5, 1'b1);    // stalled response, cmd_valid poked

    // Reset in the middle of ACCESS drops the transfer.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 8'h33;
    bus.cmd_wdata_i = 8'h44;
    bus.pready_i    = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    expect_eq("pre_rst_penable", 32'(bus.penable_o), 1);
    #2 rst = 1'b1;
    #1;
    expect_eq("async_rst_psel", 32'(bus.psel_o), 0);
    expect_eq("async_rst_penable", 32'(bus.penable_o), 0);
    expect_eq("async_rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_eq("no_rsp_after_rst", 32'(bus.rsp_valid_o), 0);
      expect_eq("idle_after_rst", 32'(bus.cmd_ready_o), 1);
    end
    run_xfer(1'b0, 8'h33, 8'h00, 8'h6B, 2, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int sel, w;
      sel = $urandom_range(0, 9);
      if (sel < 6)      w = $urandom_range(0, 3);
      else if (sel < 8) w = $urandom_range(14, 16);
      else              w = $urandom_range(17, 25);
      run_xfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), w,
               $urandom_range(0, 4), 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
